// File: rtl/cache_bus_pkg.sv
// Shared definitions for the CPU-side cache bus: C1 command codes,
// bus widths, cache address split and the CPU port FSM states.
package cache_bus_pkg;

  localparam int ADDR1_W  = 15;
  localparam int DATA1_W  = 16;
  localparam int CTR1_W   = 3;
  localparam int TAG_W    = 10;
  localparam int SET_W    = 5;
  localparam int OFFSET_W = 4;

  // C1 command codes; 3'b111 doubles as the cache's RESPONSE code
  typedef enum logic [CTR1_W-1:0] {
    C1_NOP        = 3'b000,
    C1_READ8      = 3'b001,
    C1_READ16     = 3'b010,
    C1_READ32     = 3'b011,
    C1_INVALIDATE = 3'b100,
    C1_WRITE8     = 3'b101,
    C1_WRITE16    = 3'b110,
    C1_WRITE32    = 3'b111
  } c1_cmd_t;

  localparam logic [CTR1_W-1:0] C1_RESPONSE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OFFSET,
    ST_REQ,
    ST_WAIT,
    ST_RESP1,
    ST_RESP2,
    ST_TURN
  } port_state_t;

  // Reads are 001..011
  function automatic logic cmd_is_read(input logic [CTR1_W-1:0] cmd);
    return ~cmd[2] & (cmd[1] | cmd[0]);
  endfunction

  // Writes are 101..111
  function automatic logic cmd_is_write(input logic [CTR1_W-1:0] cmd);
    return cmd[2] & (cmd[1] | cmd[0]);
  endfunction

endpackage

// File: rtl/cache_cpu_port.sv
// CPU-facing bus front end of the L1 cache. Collects a multi-cycle CPU
// bus transaction into one request for the cache core, owns the bus while
// the core works, then returns the response and releases the bus.
// Optional watchdog: define CACHE_CPU_PORT_TIMEOUT_EN to abort requests
// that sit in REQ+WAIT for TIMEOUT_CYCLES cycles.
module cache_cpu_port
  import cache_bus_pkg::*;
#(
  parameter int ADDR1_BUS_SIZE    = ADDR1_W,
  parameter int DATA1_BUS_SIZE    = DATA1_W,
  parameter int CTR1_BUS_SIZE     = CTR1_W,
  parameter int CACHE_TAG_SIZE    = TAG_W,
  parameter int CACHE_SET_SIZE    = SET_W,
  parameter int CACHE_OFFSET_SIZE = OFFSET_W,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                                                        CLK,
  input  logic                                                        RESET,
  input  logic [ADDR1_BUS_SIZE-1:0]                                   A1,
  inout  logic [DATA1_BUS_SIZE-1:0]                                   D1,
  inout  logic [CTR1_BUS_SIZE-1:0]                                    C1,
  output logic                                                        req_valid,
  input  logic                                                        req_ready,
  output logic [CTR1_BUS_SIZE-1:0]                                    req_cmd,
  output logic [CACHE_TAG_SIZE+CACHE_SET_SIZE+CACHE_OFFSET_SIZE-1:0]  req_addr,
  output logic [2*DATA1_BUS_SIZE-1:0]                                 req_wdata,
  input  logic                                                        rsp_valid,
  input  logic [2*DATA1_BUS_SIZE-1:0]                                 rsp_rdata,
  output logic                                                        timeout_err
);

  port_state_t state_reg, state_next;

  logic [CTR1_BUS_SIZE-1:0]     cmd_reg;
  logic [ADDR1_BUS_SIZE-1:0]    tag_set_reg;
  logic [CACHE_OFFSET_SIZE-1:0] off_reg;
  logic [2*DATA1_BUS_SIZE-1:0]  wdata_reg;
  logic [2*DATA1_BUS_SIZE-1:0]  rdata_reg;

  logic                         c1_oe;
  logic [CTR1_BUS_SIZE-1:0]     c1_out;
  logic                         d1_oe;
  logic [DATA1_BUS_SIZE-1:0]    d1_out;
  logic                         cmd_seen;
  logic                         tmo_expired;
  logic                         timeout_hit;

  // A floating or unknown C1 must never start a transaction
  assign cmd_seen = (^C1 !== 1'bx) && (C1 != C1_NOP);

  assign C1 = c1_oe ? c1_out : 'z;
  assign D1 = d1_oe ? d1_out : 'z;

  assign req_cmd     = cmd_reg;
  assign req_addr    = {tag_set_reg, off_reg};
  assign req_wdata   = wdata_reg;
  assign timeout_err = timeout_hit;

`ifdef CACHE_CPU_PORT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_reg;

  // Count cycles spent in REQ+WAIT, restarting whenever REQ is entered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_OFFSET) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_REQ || state_reg == ST_WAIT) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // cnt_reg holds completed cycles, so this fires during the final allowed cycle
  assign tmo_expired = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, request strobe, bus drivers and watchdog pulse
  always_comb begin
    state_next  = state_reg;
    req_valid   = 1'b0;
    c1_oe       = 1'b0;
    c1_out      = C1_NOP;
    d1_oe       = 1'b0;
    d1_out      = '0;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_seen) state_next = ST_OFFSET;
      end
      ST_OFFSET: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        c1_oe = 1'b1;
        if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_RESP1;
        end else begin
          req_valid = 1'b1;
          if (req_ready) state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        c1_oe = 1'b1;
        // A real response arriving on the expiry cycle wins over the watchdog
        if (rsp_valid) begin
          state_next = ST_RESP1;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_RESP1;
        end
      end
      ST_RESP1: begin
        c1_oe  = 1'b1;
        c1_out = C1_RESPONSE;
        if (cmd_is_read(cmd_reg)) begin
          d1_oe  = 1'b1;
          d1_out = (cmd_reg == C1_READ8) ? {{(DATA1_BUS_SIZE-8){1'b0}}, rdata_reg[7:0]}
                                         : rdata_reg[DATA1_BUS_SIZE-1:0];
        end
        state_next = (cmd_reg == C1_READ32) ? ST_RESP2 : ST_TURN;
      end
      ST_RESP2: begin
        c1_oe      = 1'b1;
        c1_out     = C1_RESPONSE;
        d1_oe      = 1'b1;
        d1_out     = rdata_reg[2*DATA1_BUS_SIZE-1:DATA1_BUS_SIZE];
        state_next = ST_TURN;
      end
      ST_TURN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture command, address, write data and read data as the transaction advances
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_reg     <= '0;
      tag_set_reg <= '0;
      off_reg     <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_seen) begin
            cmd_reg     <= C1;
            tag_set_reg <= A1;
            wdata_reg   <= cmd_is_write(C1) ? {{DATA1_BUS_SIZE{1'b0}}, D1} : '0;
          end
        end
        ST_OFFSET: begin
          // Invalidate works on a whole line, so the offset is meaningless
          off_reg <= (cmd_reg == C1_INVALIDATE) ? '0 : A1[CACHE_OFFSET_SIZE-1:0];
          if (cmd_reg == C1_WRITE32) begin
            wdata_reg[2*DATA1_BUS_SIZE-1:DATA1_BUS_SIZE] <= D1;
          end
        end
        ST_REQ: begin
          if (tmo_expired) rdata_reg <= '0;
        end
        ST_WAIT: begin
          if (rsp_valid) begin
            rdata_reg <= rsp_rdata;
          end else if (tmo_expired) begin
            rdata_reg <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_cpu_port.sv
// Scoreboard bench for cache_cpu_port: a CPU driver pushes expected core
// requests, a core model checks them and pushes expected bus responses,
// and a bus monitor pops and compares every response it sees.
module tb_cache_cpu_port;

`ifdef CACHE_CPU_PORT_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [14:0] A1;
  wire  [15:0] D1;
  wire  [2:0]  C1;
  logic        req_valid, req_ready, rsp_valid, timeout_err;
  logic [2:0]  req_cmd;
  logic [18:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;

  logic [15:0] cpu_d;
  logic        cpu_d_oe;
  logic [2:0]  cpu_c;
  logic        cpu_c_oe;
  assign D1 = cpu_d_oe ? cpu_d : 'z;
  assign C1 = cpu_c_oe ? cpu_c : 'z;

  cache_cpu_port #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .A1(A1), .D1(D1), .C1(C1),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  cmd;
    logic [18:0] addr;
    logic [31:0] wdata;
    int          first_cyc;
  } req_exp_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] rdata;
    int          cyc;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  // Core model knobs
  bit          core_hold  = 1'b0;
  int          core_stall = 0;
  int          core_delay = 0;
  bit          fix_en     = 1'b0;
  logic [31:0] fix_rdata  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Undriven bus reads as z in a 4-state simulator and as 0 in a 2-state one
  function automatic logic quiet16(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  function automatic logic quiet3(input logic [2:0] v);
    return (v === 3'bzzz) || (v === 3'b000);
  endfunction

  function automatic logic [31:0] wmask(input logic [2:0] cmd);
    case (cmd)
      3'b101:  return 32'h0000_00FF;
      3'b110:  return 32'h0000_FFFF;
      3'b111:  return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  // Core model: checks each request against the CPU-side expectation,
  // stalls/accepts it, then answers and records the expected bus response
  initial begin
    bit       busy;
    bit       seen;
    int       stall_left;
    int       dly;
    req_exp_t cur;
    busy = 0; seen = 0; stall_left = 0; dly = 0;
    cur = '{3'b000, 19'h0, 32'h0, 0};
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0;
    forever begin
      @(negedge CLK);
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      if (RESET) begin
        busy = 0;
        seen = 0;
      end else if (busy) begin
        if (dly > 0) begin
          dly--;
        end else if (!core_hold) begin
          rsp_valid = 1'b1;
          rsp_rdata = fix_en ? fix_rdata : $urandom;
          rsp_q.push_back('{cur.cmd, rsp_rdata, cyc + 1});
          busy = 0;
        end
      end else if (req_valid) begin
        if (!seen) begin
          seen = 1;
          stall_left = core_stall;
          chk("req_expected", 32'(req_q.size() != 0), 32'd1);
          if (req_q.size() != 0) begin
            cur = req_q.pop_front();
            chk("req_latency", cyc, cur.first_cyc);
          end
        end
        chk("req_cmd", req_cmd, cur.cmd);
        chk("req_addr", req_addr, cur.addr);
        if (wmask(cur.cmd) != 0) chk("req_wdata", req_wdata & wmask(cur.cmd), cur.wdata & wmask(cur.cmd));
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          req_ready = 1'b1;
          busy = 1;
          seen = 0;
          dly = core_delay;
        end
      end
    end
  end

  // Bus monitor: pops the expected response whenever the port drives RESPONSE
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (!RESET && !cpu_c_oe && C1 === 3'b111) begin
        chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          chk("rsp1_cycle", cyc, e.cyc);
          if (e.cmd inside {3'b001, 3'b010, 3'b011}) begin
            chk("rsp1_d1", 32'(D1), (e.cmd == 3'b001) ? {24'h0, e.rdata[7:0]} : {16'h0, e.rdata[15:0]});
          end else begin
            chk("rsp1_d1_released", 32'(quiet16(D1)), 32'd1);
          end
          if (e.cmd == 3'b011) begin
            @(negedge CLK);
            #1;
            chk("rsp2_c1", 32'(C1), 32'h7);
            chk("rsp2_d1", 32'(D1), {16'h0, e.rdata[31:16]});
          end
          @(negedge CLK);
          #1;
          chk("turn_c1_released", 32'(quiet3(C1)), 32'd1);
          chk("turn_d1_released", 32'(quiet16(D1)), 32'd1);
          done_cnt++;
        end
      end
    end
  end

  // CPU side of one transaction; returns the command cycle number
  task automatic issue(input logic [2:0] cmd, input logic [14:0] a1, input logic [3:0] off,
                       input logic [15:0] d0, input logic [15:0] d1, output int c0);
    req_exp_t r;
    @(negedge CLK);
    c0 = cyc;
    r.cmd = cmd;
    r.addr = {a1, (cmd == 3'b100) ? 4'h0 : off};
    r.wdata = {(cmd == 3'b111) ? d1 : 16'h0, d0};
    r.first_cyc = cyc + 2;
    req_q.push_back(r);
    cpu_c = cmd; cpu_c_oe = 1'b1; A1 = a1;
    cpu_d = d0;  cpu_d_oe = cmd[2] && (cmd != 3'b100);
    @(negedge CLK);
    cpu_c_oe = 1'b0;
    A1 = {11'($urandom), off};
    cpu_d = d1; cpu_d_oe = (cmd == 3'b111);
    @(negedge CLK);
    cpu_d_oe = 1'b0;
    A1 = 15'($urandom);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300 && done_cnt < target; i++) @(negedge CLK);
    chk("txn_complete", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic run_one(input logic [2:0] cmd, input logic [14:0] a1, input logic [3:0] off,
                         input logic [15:0] d0, input logic [15:0] d1);
    int c0;
    int target;
    target = done_cnt + 1;
    issue(cmd, a1, off, d0, d1, c0);
    $display("txn cmd=%0d a1=%h off=%h d0=%h d1=%h at cycle %0d", cmd, a1, off, d0, d1, c0);
    wait_done(target);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    RESET = 1'b1; A1 = '0; cpu_c = '0; cpu_c_oe = 1'b0; cpu_d = '0; cpu_d_oe = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_cmd", 32'(req_cmd), 32'd0);
    chk("rst_req_addr", 32'(req_addr), 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_c1_released", 32'(quiet3(C1)), 32'd1);
    chk("rst_d1_released", 32'(quiet16(D1)), 32'd1);
    RESET = 1'b0;

    // Directed transactions
    fix_en = 1; fix_rdata = 32'h0000_00AB;
    run_one(3'b001, 15'h01A3, 4'h5, 16'h0, 16'h0);
    fix_en = 0;
    run_one(3'b111, 15'h2B4C, 4'h2, 16'h5678, 16'h1234);
    core_stall = 3; fix_en = 1; fix_rdata = 32'hDEAD_BEEF;
    run_one(3'b011, 15'h7FFF, 4'hC, 16'h0, 16'h0);
    core_stall = 0; fix_en = 0;
    run_one(3'b100, 15'h0155, 4'hF, 16'h0, 16'h0);

    // Reset while the port waits for the core
    core_hold = 1;
    issue(3'b011, 15'h3C3C, 4'h9, 16'h0, 16'h0, c0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rstwait_c1_released", 32'(quiet3(C1)), 32'd1);
    chk("rstwait_d1_released", 32'(quiet16(D1)), 32'd1);
    chk("rstwait_req_valid", 32'(req_valid), 32'd0);
    chk("rstwait_req_addr", 32'(req_addr), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    core_hold = 0;
    run_one(3'b010, 15'h1111, 4'h3, 16'h0, 16'h0);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      core_stall = $urandom_range(0, 3);
      core_delay = $urandom_range(0, 3);
      run_one(3'($urandom_range(1, 7)), 15'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
    end
    core_stall = 0; core_delay = 0;

`ifdef CACHE_CPU_PORT_TIMEOUT_EN
    // Watchdog: the core never accepts, REQ+WAIT expires at its 8th cycle
    begin
      int target;
      target = done_cnt + 1;
      core_stall = 1000; core_hold = 1;
      issue(3'b010, 15'h0ABC, 4'h1, 16'h0, 16'h0, c0);
      rsp_q.push_back('{3'b010, 32'h0, c0 + 10});
      while (cyc < c0 + 8) @(negedge CLK);
      chk("tmo_err_before", 32'(timeout_err), 32'd0);
      chk("tmo_req_valid_before", 32'(req_valid), 32'd1);
      @(negedge CLK);
      chk("tmo_err_pulse", 32'(timeout_err), 32'd1);
      chk("tmo_req_valid_dropped", 32'(req_valid), 32'd0);
      @(negedge CLK);
      chk("tmo_err_after", 32'(timeout_err), 32'd0);
      wait_done(target);
    end
`endif

    repeat (3) @(negedge CLK);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
